cbus_rr_arbiter: RTL and testbench
==================================

// Module: cbus_rr_arbiter
// PURPOSE
//  N-to-1 CBus arbiter with fixed-priority or round-robin selection and a transaction watchdog.
//  Sits between the CPU-side CBus masters (ifetch, dmem, PTW) and the single memory-side CBus.
//  Grants one master at a time and holds the grant until its burst completes (oresp.last).
//  Adds one cycle of grant latency per transaction.
// PARAMETERS
//  NUM_INPUTS    2   number of masters, >=1
//  ROUND_ROBIN   1   1: rotating priority; 0: fixed priority, lowest index wins
//  TIMEOUT       0   max BUSY cycles without oresp.last; 0 disables the watchdog
//  CNT_W         32  width of each perf counter (perf option only)
//  IDX_W (local)     max(1,$clog2(NUM_INPUTS))
// PORTS
//  clk          in   1               clock
//  reset        in   1               synchronous, active-low
//  ireqs        in   cbus_req_t[N]   master requests
//  iresps       out  cbus_resp_t[N]  master responses
//  oreq         out  cbus_req_t      request to memory side
//  oresp        in   cbus_resp_t     response from memory side
//  busy         out  1               a grant is active
//  grant_idx    out  IDX_W           index of the granted master; valid while busy=1
//  timeout_err  out  1               one-cycle pulse when the watchdog fires
//  perf_grants  out  CNT_W[N]        per-master grant count (CBUS_ARB_PERF_EN only)
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - state=IDLE; busy=0; grant_idx=0; rr_ptr=N-1; timer=0; timeout_err=0; counters=0.
//   - Any in-flight grant is dropped immediately. oreq and iresps are '0 from the next cycle.
//  State machine: IDLE, BUSY
//   IDLE
//    - oreq='0; iresps='0.
//    - sel = first i with ireqs[i].valid.
//    - Search order: i=0..N-1 when ROUND_ROBIN=0; rr_ptr+1, rr_ptr+2, ... (mod N) when ROUND_ROBIN=1.
//    - If any request is valid: state<=BUSY, grant_idx<=sel, timer<=0. Grant latency is 1 cycle.
//   BUSY
//    - oreq = ireqs[grant_idx], passed through combinationally.
//    - iresps[grant_idx] = oresp; all other iresps='0.
//    - Non-granted masters see ready=0, last=0 and must hold their requests.
//    - When oresp.last=1: state<=IDLE at the end of that cycle; rr_ptr<=grant_idx.
//    - One mandatory IDLE cycle separates transactions. This gives the finished master a cycle to drop valid.
//    - Watchdog (TIMEOUT>0): timer increments each BUSY cycle without last.
//      When timer==TIMEOUT-1 and last=0: state<=IDLE, timeout_err=1 for the next cycle.
//      rr_ptr<=grant_idx so the hung master loses priority.
//    - last and the timeout landing in the same cycle: the transaction completes normally, no error.
//    - Granted master dropping valid mid-burst is a protocol error.
//      The arbiter stays BUSY until last or the timeout.
//  Arithmetic
//   - rr_ptr wraps modulo N. N=1 always grants index 0.
//   - timer is $clog2(TIMEOUT+1) bits and never wraps.
//  Simultaneous requests: exactly one grant per IDLE cycle; the others wait.
//   With ROUND_ROBIN=1, no master waits more than N-1 transactions.
// CONFIGURATION
//  CBUS_ARB_PERF_EN defined
//   - perf_grants[i] increments on each IDLE->BUSY grant to master i.
//   - Saturates at all-ones and is cleared by reset.
//  CBUS_ARB_PERF_EN undefined
//   - The perf_grants port and the counters are absent. All other behaviour is identical.
// TESTING
//  1. Reset with ireqs[0].valid=1 held -> busy=0 and oreq='0 during reset.
//     First posedge after release: busy=1, grant_idx=0.
//  2. N=3, RR=1, all three valid continuously, each burst last after 2 cycles -> grant order 0,1,2,0.
//     Each grant has 1 IDLE cycle between bursts.
//  3. N=3, RR=0, masters 1 and 2 valid -> master 1 served repeatedly; master 2 granted only once master 1 drops valid.
//  4. TIMEOUT=8, memory never returns last -> busy for 8 cycles, then timeout_err=1 for 1 cycle.
//     The next grant goes to another valid master.
//  5. oresp.last arrives on BUSY cycle 8 with TIMEOUT=8 -> normal completion, timeout_err stays 0.
//  6. PERF_EN, CNT_W=4, 20 grants to master 0 -> perf_grants[0]=15 (saturated), perf_grants[1]=0.

Source files
------------

// File: rtl/cbus_rr_arbiter_if.sv
// CBus request/response types and the bundled CPU-side/memory-side bus used by cbus_rr_arbiter.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

interface cbus_rr_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // slave: the arbiter itself; master: the environment driving requests and memory responses
  modport slave  (input ireqs, input oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input iresps, input oreq);
endinterface

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter (fixed priority or round-robin) with a per-transaction watchdog.
// Optional per-master grant counters are built when CBUS_ARB_PERF_EN is defined.
module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = 32,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  cbus_rr_arbiter_if.slave        bus,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    timeout_err
`ifdef CBUS_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]        perf_grants [NUM_INPUTS]
`endif
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  grant_next;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_next;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_next;
  logic              terr_next;

  if (NUM_INPUTS < 1 || CNT_W < 1) begin : g_cfg_check
    $error("cbus_rr_arbiter: NUM_INPUTS and CNT_W must be at least 1");
  end

  // Search starts just after the last served master so a busy master cannot starve the others
  always_comb begin : select
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (ROUND_ROBIN != 0) begin
        cand = (int'(rr_ptr) + 1 + k) % NUM_INPUTS;
      end else begin
        cand = k;
      end
      cand_idx = IDX_W'(cand);
      if (!sel_found && bus.ireqs[cand_idx].valid) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin : next_state
    state_next = state;
    grant_next = grant_idx;
    rr_next    = rr_ptr;
    timer_next = timer;
    terr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = BUSY;
          grant_next = sel_idx;
          timer_next = '0;
        end
      end
      BUSY: begin
        // A last beat wins over a watchdog expiry landing in the same cycle
        if (bus.oresp.last) begin
          state_next = IDLE;
          rr_next    = grant_idx;
        end else if (TIMEOUT > 0) begin
          if (timer == TMR_W'(TIMEOUT - 1)) begin
            state_next = IDLE;
            rr_next    = grant_idx;
            terr_next  = 1'b1;
          end else begin
            timer_next = timer + TMR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : route
    bus.oreq   = '0;
    bus.iresps = '{default: '0};
    if (state == BUSY) begin
      bus.oreq              = bus.ireqs[grant_idx];
      bus.iresps[grant_idx] = bus.oresp;
    end
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk) begin : regs
    if (!reset) begin
      state       <= IDLE;
      grant_idx   <= '0;
      rr_ptr      <= IDX_W'(NUM_INPUTS - 1);
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      grant_idx   <= grant_next;
      rr_ptr      <= rr_next;
      timer       <= timer_next;
      timeout_err <= terr_next;
    end
  end

`ifdef CBUS_ARB_PERF_EN
  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk) begin : perf
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        perf_grants[i] <= '0;
      end
    end else if (state == IDLE && sel_found && perf_grants[sel_idx] != '1) begin
      perf_grants[sel_idx] <= perf_grants[sel_idx] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter: round-robin/timeout instance A and fixed-priority instance B,
// with expected grant order kept in a scoreboard queue.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  cbus_req_t  reqs [3];
  cbus_resp_t resp_a;
  cbus_resp_t resp_b;
  logic       busy_a, busy_b, terr_a, terr_b;
  logic [1:0] grant_a, grant_b;
`ifdef CBUS_ARB_PERF_EN
  logic [3:0]  perf_a [3];
  logic [31:0] perf_b [3];
`endif

  int checks = 0;
  int fails  = 0;
  int expq [$];

  always #5 clk = ~clk;

  cbus_rr_arbiter_if #(.NUM_INPUTS(3)) bus_a ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(3)) bus_b ();

  assign bus_a.ireqs = reqs;
  assign bus_b.ireqs = reqs;
  assign bus_a.oresp = resp_a;
  assign bus_b.oresp = resp_b;

  cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(1), .TIMEOUT(8), .CNT_W(4)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_a),
    .busy        (busy_a),
    .grant_idx   (grant_a),
    .timeout_err (terr_a)
`ifdef CBUS_ARB_PERF_EN
    ,
    .perf_grants (perf_a)
`endif
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_b),
    .busy        (busy_b),
    .grant_idx   (grant_b),
    .timeout_err (terr_b)
`ifdef CBUS_ARB_PERF_EN
    ,
    .perf_grants (perf_b)
`endif
  );

  function automatic logic obsBusy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [1:0] obsGrant(input int sel);
    return (sel == 0) ? grant_a : grant_b;
  endfunction

  function automatic cbus_resp_t obsIresp(input int sel, input int idx);
    return (sel == 0) ? bus_a.iresps[idx] : bus_b.iresps[idx];
  endfunction

  function automatic cbus_req_t obsOreq(input int sel);
    return (sel == 0) ? bus_a.oreq : bus_b.oreq;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mask);
    for (int i = 0; i < 3; i++) reqs[i].valid = mask[i];
  endtask

  task automatic driveResp(input int sel, input cbus_resp_t r);
    if (sel == 0) resp_a = r;
    else resp_b = r;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Bounded wait for the next grant, then compare against the oldest scoreboard entry
  task automatic waitGrant(input int sel, output int waited, output int gidx);
    waited = 0;
    while (!obsBusy(sel) && waited < 20) begin
      tick();
      waited++;
    end
    gidx = (expq.size() > 0) ? expq.pop_front() : -1;
    checkOutput("grant_busy", 128'(obsBusy(sel)), 128'(1));
    checkOutput("grant_idx", 128'(obsGrant(sel)), 128'(gidx));
  endtask

  task automatic serveBurst(input int sel, input int len, input int gidx);
    cbus_resp_t r;
    for (int c = 1; c <= len; c++) begin
      r.ready = 1'b1;
      r.last  = (c == len);
      r.rdata = $urandom;
      driveResp(sel, r);
      #1;
      if (c == 1) begin
        checkOutput("iresp_granted", 128'(obsIresp(sel, gidx)), 128'(r));
        checkOutput("iresp_other", 128'(obsIresp(sel, (gidx + 1) % 3)), 128'(0));
        checkOutput("oreq_pass", 128'(obsOreq(sel)), 128'(reqs[gidx]));
      end
      tick();
    end
    driveResp(sel, '0);
    checkOutput("idle_after_last", 128'(obsBusy(sel)), 128'(0));
  endtask

  initial begin
    int w, g, cnt;
    for (int i = 0; i < 3; i++) begin
      reqs[i].valid = 1'b0;
      reqs[i].we    = i[0];
      reqs[i].addr  = 32'h1000 * (i + 1);
      reqs[i].wdata = 32'hA5A50000 + i;
    end
    resp_a = '0;
    resp_b = '0;

    // Reset held with a pending request: nothing may leak out
    applyStimulus(3'b001);
    reset = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", 128'(busy_a), 128'(0));
    checkOutput("reset_oreq", 128'(bus_a.oreq), 128'(0));
    checkOutput("reset_terr", 128'(terr_a), 128'(0));
    reset = 1'b1;
    expq.push_back(0);
    waitGrant(0, w, g);
    checkOutput("first_grant_latency", 128'(w), 128'(1));
    serveBurst(0, 1, g);
    applyStimulus(3'b000);

    // Round robin with all masters requesting continuously
    applyReset();
    applyStimulus(3'b111);
    expq.push_back(0);
    expq.push_back(1);
    expq.push_back(2);
    expq.push_back(0);
    for (int t = 0; t < 4; t++) begin
      waitGrant(0, w, g);
      if (t == 0) checkOutput("rr_first_wait", 128'(w), 128'(1));
      else checkOutput("rr_gap", 128'(w), 128'(1));
      serveBurst(0, 2, g);
    end
    applyStimulus(3'b000);

    // Watchdog: memory never returns last
    applyReset();
    applyStimulus(3'b101);
    expq.push_back(0);
    waitGrant(0, w, g);
    cnt = 0;
    while (busy_a && cnt < 20) begin
      cnt++;
      tick();
    end
    checkOutput("timeout_busy_cycles", 128'(cnt), 128'(8));
    checkOutput("timeout_err_pulse", 128'(terr_a), 128'(1));
    expq.push_back(2);
    tick();
    checkOutput("timeout_err_clear", 128'(terr_a), 128'(0));
    waitGrant(0, w, g);
    checkOutput("timeout_regrant_wait", 128'(w), 128'(0));
    serveBurst(0, 1, g);
    applyStimulus(3'b000);

    // last on the final allowed BUSY cycle completes normally
    applyStimulus(3'b010);
    expq.push_back(1);
    waitGrant(0, w, g);
    serveBurst(0, 8, g);
    checkOutput("late_last_no_err", 128'(terr_a), 128'(0));
    applyStimulus(3'b000);
    tick();
    checkOutput("late_last_no_err_next", 128'(terr_a), 128'(0));

    // Fixed priority: master 1 keeps winning until it drops valid
    applyReset();
    applyStimulus(3'b110);
    for (int t = 0; t < 3; t++) expq.push_back(1);
    for (int t = 0; t < 3; t++) begin
      waitGrant(1, w, g);
      serveBurst(1, 1, g);
    end
    applyStimulus(3'b100);
    expq.push_back(2);
    waitGrant(1, w, g);
    checkOutput("fp_switch_wait", 128'(w), 128'(1));
    serveBurst(1, 1, g);
    applyStimulus(3'b000);

`ifdef CBUS_ARB_PERF_EN
    // Grant counters saturate at all-ones
    applyReset();
    applyStimulus(3'b001);
    for (int t = 0; t < 20; t++) begin
      expq.push_back(0);
      waitGrant(0, w, g);
      serveBurst(0, 1, g);
    end
    applyStimulus(3'b000);
    tick();
    checkOutput("perf0_saturated", 128'(perf_a[0]), 128'((20 > 15) ? 15 : 20));
    checkOutput("perf1_zero", 128'(perf_a[1]), 128'(0));
    checkOutput("perf2_zero", 128'(perf_a[2]), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
